// File: rtl/pe_sequencer.sv
// SIMD PE array instruction sequencer: program fetch, decode, RAM-latency
// stalls, single-level hardware loops and vector result collection.
module pe_sequencer #(
  parameter int DATA_LEN      = 32,
  parameter int PE_ELEMENTS   = 4,
  parameter int PC_LEN        = 12,
  parameter int OPCODE_LEN    = 4,
  parameter int ADDR_LEN      = 8,
  parameter int INST_LEN      = OPCODE_LEN + ADDR_LEN,
  parameter int PE_OPCODE_LEN = 4,
  parameter int RAM_LAT       = 1,
  parameter int S2_DELAY      = 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [PC_LEN-1:0]               inst_read_addr,
  input  logic [INST_LEN-1:0]             inst_read_data,
  output logic [PE_OPCODE_LEN-1:0]        pe_opcode,
  output logic [PE_ELEMENTS*DATA_LEN-1:0] data_a,
  output logic [PE_ELEMENTS*DATA_LEN-1:0] data_b,
  output logic [ADDR_LEN-1:0]             ram_a_read_addr,
  output logic [ADDR_LEN-1:0]             ram_b_read_addr,
  output logic                            ram_a_rd_en,
  output logic                            ram_b_rd_en,
  input  logic [PE_ELEMENTS*DATA_LEN-1:0] ram_a_read_data,
  input  logic [PE_ELEMENTS*DATA_LEN-1:0] ram_b_read_data,
  input  logic                            pe_stage_1_valid,
  input  logic [PE_ELEMENTS*DATA_LEN-1:0] pe_stage_1_output,
  input  logic                            pe_stage_2_valid,
  input  logic [DATA_LEN-1:0]             pe_stage_2_output,
  output logic [ADDR_LEN-1:0]             ram_result_write_addr,
  output logic [PE_ELEMENTS*DATA_LEN-1:0] ram_result_write_data,
  output logic                            ram_result_wr_en
);

  localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  localparam logic [OPCODE_LEN-1:0] OP_FETCH_A = OPCODE_LEN'(1);
  localparam logic [OPCODE_LEN-1:0] OP_FETCH_B = OPCODE_LEN'(2);
  localparam logic [OPCODE_LEN-1:0] OP_ADD     = OPCODE_LEN'(3);
  localparam logic [OPCODE_LEN-1:0] OP_SUB     = OPCODE_LEN'(4);
  localparam logic [OPCODE_LEN-1:0] OP_MUL     = OPCODE_LEN'(5);
  localparam logic [OPCODE_LEN-1:0] OP_DOTP    = OPCODE_LEN'(6);
  localparam logic [OPCODE_LEN-1:0] OP_ST_S1   = OPCODE_LEN'(7);
  localparam logic [OPCODE_LEN-1:0] OP_ST_S2   = OPCODE_LEN'(8);
  localparam logic [OPCODE_LEN-1:0] OP_ST_RES  = OPCODE_LEN'(9);
  localparam logic [OPCODE_LEN-1:0] OP_STOP    = OPCODE_LEN'(10);
  localparam logic [OPCODE_LEN-1:0] OP_LOOP_B  = OPCODE_LEN'(11);
  localparam logic [OPCODE_LEN-1:0] OP_LOOP_E  = OPCODE_LEN'(12);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [PC_LEN-1:0]   pc_q, pc_d;
  logic [PC_LEN-1:0]   loop_start_q, loop_start_d;
  logic [ADDR_LEN-1:0] loop_cnt_q, loop_cnt_d;
  logic [CW-1:0]       wait_q, wait_d;

  logic [PE_ELEMENTS-1:0][DATA_LEN-1:0] buf_q, buf_d;

  logic [OPCODE_LEN-1:0] op;
  logic [ADDR_LEN-1:0]   field;
  logic                  s2_dly_v;

  assign op    = inst_read_data[OPCODE_LEN-1:0];
  assign field = inst_read_data[INST_LEN-1:OPCODE_LEN];

  assign inst_read_addr        = pc_q;
  assign data_a                = ram_a_read_data;
  assign data_b                = ram_b_read_data;
  assign ram_result_write_data = buf_q;

  always_comb begin
    state_d               = state_q;
    pc_d                  = pc_q;
    loop_start_d          = loop_start_q;
    loop_cnt_d            = loop_cnt_q;
    wait_d                = wait_q;
    busy                  = 1'b0;
    done                  = 1'b0;
    pe_opcode             = '0;
    ram_a_rd_en           = 1'b0;
    ram_b_rd_en           = 1'b0;
    ram_a_read_addr       = '0;
    ram_b_read_addr       = '0;
    ram_result_write_addr = '0;
    ram_result_wr_en      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_RUN: begin
        busy                  = 1'b1;
        ram_a_read_addr       = field;
        ram_b_read_addr       = field;
        ram_result_write_addr = field;
        pc_d                  = pc_q + 1'b1;
        unique case (op)
          OP_FETCH_A, OP_FETCH_B: begin
            ram_a_rd_en = (op == OP_FETCH_A);
            ram_b_rd_en = (op == OP_FETCH_B);
            if (RAM_LAT > 0) begin
              state_d = S_WAIT;
              wait_d  = CW'(RAM_LAT - 1);
            end
          end
          OP_ADD:   pe_opcode = PE_OPCODE_LEN'(1);
          OP_SUB:   pe_opcode = PE_OPCODE_LEN'(2);
          OP_MUL:   pe_opcode = PE_OPCODE_LEN'(3);
          OP_DOTP:  pe_opcode = PE_OPCODE_LEN'(4);
          OP_ST_S1: pe_opcode = PE_OPCODE_LEN'(5);
          OP_ST_S2: pe_opcode = PE_OPCODE_LEN'(6);
          OP_ST_RES: begin
            pe_opcode        = PE_OPCODE_LEN'(7);
            ram_result_wr_en = 1'b1;
          end
          OP_STOP: begin
            pe_opcode = PE_OPCODE_LEN'(8);
            pc_d      = pc_q;
            state_d   = S_DONE;
          end
          OP_LOOP_B: begin
            loop_start_d = pc_q + 1'b1;
            loop_cnt_d   = field;
          end
          OP_LOOP_E: begin
            if (loop_cnt_q != '0) begin
              loop_cnt_d = loop_cnt_q - 1'b1;
              pc_d       = loop_start_q;
            end
          end
          default: ;
        endcase
      end
      S_WAIT: begin
        busy = 1'b1;
        if (wait_q == '0) begin
          state_d = S_RUN;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
        pc_d    = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage-2 valid is realigned to the scalar data that trails it
  generate
    if (S2_DELAY == 0) begin : g_s2_direct
      assign s2_dly_v = pe_stage_2_valid;
    end else begin : g_s2_delay
      logic [S2_DELAY-1:0] sr_q, sr_d;
      logic [S2_DELAY:0]   sr_ext;
      always_comb begin
        sr_ext = {sr_q, pe_stage_2_valid};
        sr_d   = sr_ext[S2_DELAY-1:0];
      end
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          sr_q <= '0;
        end else begin
          sr_q <= sr_d;
        end
      end
      assign s2_dly_v = sr_q[S2_DELAY-1];
    end
  endgenerate

  always_comb begin
    buf_d = buf_q;
    if (ram_result_wr_en) begin
      buf_d = buf_q;
    end else if (pe_stage_1_valid) begin
      buf_d = pe_stage_1_output;
    end else if (s2_dly_v) begin
      for (int i = PE_ELEMENTS - 1; i > 0; i--) begin
        buf_d[i] = buf_q[i-1];
      end
      buf_d[0] = pe_stage_2_output;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      loop_start_q <= '0;
      loop_cnt_q   <= '0;
      wait_q       <= '0;
      buf_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      loop_start_q <= loop_start_d;
      loop_cnt_q   <= loop_cnt_d;
      wait_q       <= wait_d;
      buf_q        <= buf_d;
    end
  end

endmodule

// File: tb/tb_pe_sequencer.sv
// Scoreboard bench for pe_sequencer: an ISA-level program interpreter
// predicts every cycle and every result write.
module tb_pe_sequencer;

  localparam int DL   = 32;
  localparam int PE   = 4;
  localparam int PCL  = 12;
  localparam int OL   = 4;
  localparam int AL   = 8;
  localparam int IL   = OL + AL;
  localparam int POL  = 4;
  localparam int LAT  = 1;
  localparam int S2D  = 1;
  localparam int VW   = PE * DL;
  localparam int MAXT = 1024;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           start = 1'b0;
  logic           busy, done;
  logic [PCL-1:0] inst_read_addr;
  logic [IL-1:0]  inst_read_data;
  logic [POL-1:0] pe_opcode;
  logic [VW-1:0]  data_a, data_b;
  logic [AL-1:0]  ram_a_read_addr, ram_b_read_addr;
  logic           ram_a_rd_en, ram_b_rd_en;
  logic [VW-1:0]  ram_a_read_data = '0;
  logic [VW-1:0]  ram_b_read_data = '0;
  logic           pe_stage_1_valid = 1'b0;
  logic [VW-1:0]  pe_stage_1_output = '0;
  logic           pe_stage_2_valid = 1'b0;
  logic [DL-1:0]  pe_stage_2_output = '0;
  logic [AL-1:0]  ram_result_write_addr;
  logic [VW-1:0]  ram_result_write_data;
  logic           ram_result_wr_en;

  logic [IL-1:0] prog [64];
  assign inst_read_data = prog[inst_read_addr[5:0]];

  always #5 clk = ~clk;

  pe_sequencer #(
    .DATA_LEN(DL), .PE_ELEMENTS(PE), .PC_LEN(PCL), .OPCODE_LEN(OL),
    .ADDR_LEN(AL), .INST_LEN(IL), .PE_OPCODE_LEN(POL),
    .RAM_LAT(LAT), .S2_DELAY(S2D)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .inst_read_addr(inst_read_addr), .inst_read_data(inst_read_data),
    .pe_opcode(pe_opcode), .data_a(data_a), .data_b(data_b),
    .ram_a_read_addr(ram_a_read_addr), .ram_b_read_addr(ram_b_read_addr),
    .ram_a_rd_en(ram_a_rd_en), .ram_b_rd_en(ram_b_rd_en),
    .ram_a_read_data(ram_a_read_data), .ram_b_read_data(ram_b_read_data),
    .pe_stage_1_valid(pe_stage_1_valid),
    .pe_stage_1_output(pe_stage_1_output),
    .pe_stage_2_valid(pe_stage_2_valid),
    .pe_stage_2_output(pe_stage_2_output),
    .ram_result_write_addr(ram_result_write_addr),
    .ram_result_write_data(ram_result_write_data),
    .ram_result_wr_en(ram_result_wr_en)
  );

  typedef struct {
    logic           busy;
    logic           done;
    logic           rda;
    logic           rdb;
    logic           wr;
    logic [PCL-1:0] pc;
    logic [POL-1:0] pe;
    logic [AL-1:0]  addr;
    logic [VW-1:0]  wdata;
    logic [VW-1:0]  da;
    logic [VW-1:0]  db;
  } rec_t;

  rec_t          exp_tr [MAXT];
  logic          st  [MAXT];
  logic          s1v [MAXT];
  logic          s2v [MAXT];
  logic [VW-1:0] s1d [MAXT];
  logic [DL-1:0] s2d [MAXT];
  logic [VW-1:0] ra  [MAXT];
  logic [VW-1:0] rb  [MAXT];
  int            ncyc;

  rec_t trace_q[$];
  rec_t wr_q[$];
  rec_t m_e, m_w;
  int   total = 0;
  int   bad = 0;
  bit   active = 0;
  int   add_cnt = 0;

  task automatic chk(input string nm, input logic [VW-1:0] got,
                     input logic [VW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [IL-1:0] ins(input int op, input int f);
    logic [IL-1:0] v;
    v = {AL'(f), OL'(op)};
    return v;
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = '0;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXT; i++) begin
      s1v[i] = 1'b0;
      s2v[i] = 1'b0;
      s1d[i] = '0;
      s2d[i] = '0;
      ra[i]  = rnd_vec();
      rb[i]  = rnd_vec();
    end
  endtask

  task automatic rand_stim();
    for (int i = 0; i < MAXT; i++) begin
      s1v[i] = ($urandom_range(0, 7) == 0);
      s2v[i] = $urandom_range(0, 1) == 1;
      s1d[i] = rnd_vec();
      s2d[i] = $urandom;
      ra[i]  = rnd_vec();
      rb[i]  = rnd_vec();
    end
  endtask

  function automatic rec_t blank(input int t);
    rec_t r;
    r.busy  = 1'b0;
    r.done  = 1'b0;
    r.rda   = 1'b0;
    r.rdb   = 1'b0;
    r.wr    = 1'b0;
    r.pc    = '0;
    r.pe    = '0;
    r.addr  = '0;
    r.wdata = '0;
    r.da    = ra[t];
    r.db    = rb[t];
    return r;
  endfunction

  // Interpret the program instruction by instruction; t=0 is the start cycle
  task automatic model();
    int t, pc, lc, ls, op, f;
    bit stopped;
    rec_t r;
    logic [VW-1:0] bufv;
    t = 0;
    exp_tr[t] = blank(t);
    t = 1;
    pc = 0; lc = 0; ls = 0;
    stopped = 0;
    while (!stopped && t < MAXT - 8 - LAT) begin
      op = int'(prog[pc % 64][OL-1:0]);
      f  = int'(prog[pc % 64][IL-1:OL]);
      r = blank(t);
      r.busy = 1'b1;
      r.pc   = PCL'(pc);
      r.addr = AL'(f);
      r.rda  = (op == 1);
      r.rdb  = (op == 2);
      r.wr   = (op == 9);
      if (op >= 3 && op <= 10) r.pe = POL'(op - 2);
      exp_tr[t] = r;
      t++;
      case (op)
        1, 2: begin
          pc = (pc + 1) % (1 << PCL);
          for (int k = 0; k < LAT; k++) begin
            r = blank(t);
            r.busy = 1'b1;
            r.pc = PCL'(pc);
            exp_tr[t] = r;
            t++;
          end
        end
        10: stopped = 1;
        11: begin
          ls = (pc + 1) % (1 << PCL);
          lc = f;
          pc = ls;
        end
        12: begin
          if (lc != 0) begin
            lc--;
            pc = ls;
          end else begin
            pc = (pc + 1) % (1 << PCL);
          end
        end
        default: pc = (pc + 1) % (1 << PCL);
      endcase
    end
    r = blank(t);
    r.done = 1'b1;
    r.pc = PCL'(pc);
    exp_tr[t] = r;
    t++;
    for (int k = 0; k < 3; k++) begin
      exp_tr[t] = blank(t);
      t++;
    end
    ncyc = t;
    for (int i = 0; i < MAXT; i++) st[i] = (i < ncyc - 3);
    bufv = '0;
    for (int i = 0; i < ncyc; i++) begin
      if (exp_tr[i].wr) begin
        exp_tr[i].wdata = bufv;
      end else if (s1v[i]) begin
        bufv = s1d[i];
      end else if (i >= S2D && s2v[i-S2D]) begin
        bufv = {bufv[VW-DL-1:0], s2d[i]};
      end
    end
  endtask

  task automatic zero_in();
    start = 1'b0;
    pe_stage_1_valid  = 1'b0;
    pe_stage_1_output = '0;
    pe_stage_2_valid  = 1'b0;
    pe_stage_2_output = '0;
  endtask

  task automatic reset_dut();
    zero_in();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic run_test(input string nm, input bit do_reset);
    if (do_reset) reset_dut();
    model();
    add_cnt = 0;
    active = 1;
    for (int t = 0; t < ncyc; t++) begin
      @(posedge clk);
      #1;
      start             = st[t];
      pe_stage_1_valid  = s1v[t];
      pe_stage_1_output = s1d[t];
      pe_stage_2_valid  = s2v[t];
      pe_stage_2_output = s2d[t];
      ram_a_read_data   = ra[t];
      ram_b_read_data   = rb[t];
      trace_q.push_back(exp_tr[t]);
      if (exp_tr[t].wr) wr_q.push_back(exp_tr[t]);
    end
    @(posedge clk);
    #1;
    zero_in();
    active = 0;
    @(negedge clk);
    total++;
    if (trace_q.size() != 0 || wr_q.size() != 0) begin
      bad++;
      $display("FAIL %s leftover trace=%0d writes=%0d", nm,
               trace_q.size(), wr_q.size());
      trace_q.delete();
      wr_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (trace_q.size() > 0) begin
      m_e = trace_q.pop_front();
      total++;
      if (busy !== m_e.busy || done !== m_e.done || inst_read_addr !== m_e.pc ||
          pe_opcode !== m_e.pe || ram_a_rd_en !== m_e.rda ||
          ram_b_rd_en !== m_e.rdb || ram_result_wr_en !== m_e.wr ||
          data_a !== m_e.da || data_b !== m_e.db ||
          (m_e.rda && ram_a_read_addr !== m_e.addr) ||
          (m_e.rdb && ram_b_read_addr !== m_e.addr)) begin
        bad++;
        $display("FAIL cycle got b%0b d%0b pc%0d pe%0d a%0b b%0b w%0b exp b%0b d%0b pc%0d pe%0d a%0b b%0b w%0b",
                 busy, done, inst_read_addr, pe_opcode, ram_a_rd_en,
                 ram_b_rd_en, ram_result_wr_en, m_e.busy, m_e.done, m_e.pc,
                 m_e.pe, m_e.rda, m_e.rdb, m_e.wr);
      end
    end
    if (ram_result_wr_en) begin
      total++;
      if (wr_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got addr=%0d exp none",
                 ram_result_write_addr);
      end else begin
        m_w = wr_q.pop_front();
        if (ram_result_write_addr !== m_w.addr ||
            ram_result_write_data !== m_w.wdata) begin
          bad++;
          $display("FAIL write got %0d/%h exp %0d/%h", ram_result_write_addr,
                   ram_result_write_data, m_w.addr, m_w.wdata);
        end
      end
    end
    if (active && pe_opcode == POL'(1)) add_cnt++;
  end

  initial begin
    clear_prog();
    clear_stim();
    reset_dut();
    @(negedge clk);
    chk("rst_busy", VW'(busy), '0);
    chk("rst_done", VW'(done), '0);
    chk("rst_pc", VW'(inst_read_addr), '0);
    chk("rst_wdata", ram_result_write_data, '0);

    // basic program with stage-1 vector {1,2,3,4}
    prog[0] = ins(1, 3);
    prog[1] = ins(2, 5);
    prog[2] = ins(3, 0);
    prog[3] = ins(7, 0);
    prog[4] = ins(9, 9);
    prog[5] = ins(10, 0);
    clear_stim();
    s1v[5] = 1'b1;
    s1d[5] = {32'd4, 32'd3, 32'd2, 32'd1};
    run_test("basic", 1);

    clear_prog();
    prog[0] = ins(11, 2);
    prog[1] = ins(3, 0);
    prog[2] = ins(12, 0);
    prog[3] = ins(10, 0);
    clear_stim();
    run_test("loop", 1);
    chk("loop_add_cnt", VW'(add_cnt), VW'(3));

    // stage-2 scalars collected, then a store while stage-1 also fires
    clear_prog();
    prog[4] = ins(9, 0);
    prog[5] = ins(9, 1);
    prog[6] = ins(10, 0);
    clear_stim();
    for (int i = 0; i < 4; i++) begin
      s2v[i]   = 1'b1;
      s2d[i+1] = DL'((i + 1) * 10);
    end
    s1v[5] = 1'b1;
    s1d[5] = rnd_vec();
    run_test("s2_collect", 1);

    // asynchronous reset in the middle of a WAIT
    clear_prog();
    prog[0] = ins(1, 3);
    prog[1] = ins(3, 0);
    prog[2] = ins(10, 0);
    clear_stim();
    reset_dut();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("run_rda", VW'(ram_a_rd_en), VW'(1));
    @(posedge clk);
    #3;
    chk("wait_busy", VW'(busy), VW'(1));
    chk("wait_rda", VW'(ram_a_rd_en), '0);
    rstn = 1'b0;
    #1;
    chk("arst_busy", VW'(busy), '0);
    chk("arst_pc", VW'(inst_read_addr), '0);
    chk("arst_pe", VW'(pe_opcode), '0);
    chk("arst_rda", VW'(ram_a_rd_en), '0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    run_test("after_reset", 0);

    for (int n = 0; n < 8; n++) begin
      int len;
      int op;
      int f;
      clear_prog();
      len = $urandom_range(4, 20);
      for (int i = 0; i < len; i++) begin
        op = $urandom_range(0, 15);
        if (op == 10) op = 0;
        f = $urandom_range(0, 255);
        if (op == 11) f = $urandom_range(0, 3);
        prog[i] = ins(op, f);
      end
      prog[len] = ins(10, 0);
      rand_stim();
      run_test("random", 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
